// File: rtl/fechadura_pkg.sv
// Shared types and constants for the door-lock design: controller/scanner states,
// key codes, BCD PIN type and the active-low seven-segment encoder.
package fechadura_pkg;

  typedef enum logic [1:0] {ST_LOCKED, ST_UNLOCKED, ST_OPEN, ST_BLOCKED} ctrl_state_t;
  typedef enum logic [1:0] {SC_SCAN, SC_DEBOUNCE, SC_HOLD} scan_state_t;

  localparam logic [3:0] KEY_STAR = 4'd15;
  localparam logic [3:0] KEY_HASH = 4'd13;

  // Four BCD digits; element 3 holds the first-typed digit.
  typedef logic [3:0][3:0] pin_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/fechadura_matrix_keypad_scan.sv
// 4x4 keypad row scanner with press/release debounce; emits a one-cycle key_valid
// with the decoded key code.
module matrix_keypad_scan
  import fechadura_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SCAN_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] lin,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CMAX = (DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  scan_state_t   state_reg, state_next;
  logic [1:0]    row_reg, row_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    pat_reg, pat_next;
  logic [3:0]    code_reg, code_next;
  logic          valid_reg, valid_next;
  logic [1:0]    low_col;

  function automatic logic [3:0] key_map(input logic [3:0] rc);
    case (rc)
      4'd0: key_map = 4'd1;   4'd1: key_map = 4'd2;   4'd2: key_map = 4'd3;   4'd3: key_map = 4'd10;
      4'd4: key_map = 4'd4;   4'd5: key_map = 4'd5;   4'd6: key_map = 4'd6;   4'd7: key_map = 4'd11;
      4'd8: key_map = 4'd7;   4'd9: key_map = 4'd8;   4'd10: key_map = 4'd9;  4'd11: key_map = 4'd12;
      4'd12: key_map = 4'd15; 4'd13: key_map = 4'd0;  4'd14: key_map = 4'd13; default: key_map = 4'd14;
    endcase
  endfunction

  // Lowest active-low column wins when several keys share the row.
  always_comb begin
    if (!pat_reg[0])      low_col = 2'd0;
    else if (!pat_reg[1]) low_col = 2'd1;
    else if (!pat_reg[2]) low_col = 2'd2;
    else                  low_col = 2'd3;
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    cnt_next   = cnt_reg;
    pat_next   = pat_reg;
    code_next  = code_reg;
    valid_next = 1'b0;
    case (state_reg)
      SC_SCAN: begin
        if (col != 4'hF) begin
          state_next = SC_DEBOUNCE;
          pat_next   = col;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(SCAN_CYCLES - 1)) begin
          cnt_next = '0;
          row_next = row_reg + 2'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SC_DEBOUNCE: begin
        if (col != pat_reg) begin
          state_next = SC_SCAN;
          cnt_next   = '0;
        end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_next = SC_HOLD;
          cnt_next   = '0;
          valid_next = 1'b1;
          code_next  = key_map({row_reg, low_col});
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SC_HOLD: begin
        if (col != 4'hF) begin
          cnt_next = '0;
        end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
          state_next = SC_SCAN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = SC_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= SC_SCAN;
      row_reg   <= 2'd0;
      cnt_reg   <= '0;
      pat_reg   <= 4'hF;
      code_reg  <= 4'd0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      cnt_reg   <= cnt_next;
      pat_reg   <= pat_next;
      code_reg  <= code_next;
      valid_reg <= valid_next;
    end
  end

  assign lin       = ~(4'b0001 << row_reg);
  assign key_valid = valid_reg;
  assign key_code  = code_reg;

endmodule

// File: rtl/fechadura_top.sv
// Door-lock controller: PIN entry, lock/unlock/lockout FSM, buzzer and displays.
// Define FECHADURA_PIN_UPDATE_EN to allow changing the master PIN while unlocked.
module fechadura_top
  import fechadura_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 20,
  parameter int          SCAN_CYCLES     = 4,
  parameter int          UNLOCK_CYCLES   = 5000,
  parameter int          BIP_CYCLES      = 8,
  parameter int          BLOCK_CYCLES    = 2000,
  parameter logic [15:0] MASTER_PIN_RST  = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_de_contato,
  input  logic       botao_interno,
  input  logic [3:0] matricial_col,
  output logic [3:0] matricial_lin,
  output logic [6:0] dispHex0,
  output logic [6:0] dispHex1,
  output logic [6:0] dispHex2,
  output logic [6:0] dispHex3,
  output logic [6:0] dispHex4,
  output logic [6:0] dispHex5,
  output logic       tranca,
  output logic       bip
);

  localparam int TMAX = (UNLOCK_CYCLES > BLOCK_CYCLES) ? UNLOCK_CYCLES : BLOCK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(BIP_CYCLES + 1);

  logic       key_valid;
  logic [3:0] key_code;

  matrix_keypad_scan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SCAN_CYCLES    (SCAN_CYCLES)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .col      (matricial_col),
    .lin      (matricial_lin),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  ctrl_state_t   state_reg, state_next;
  pin_t          buf_reg, buf_next, master_reg, master_next;
  logic [2:0]    len_reg, len_next;
  logic [1:0]    fail_reg, fail_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [BW-1:0] bip_reg, bip_next;
  logic          is_digit, key_ok, full_star;

  always_comb begin
    is_digit  = (key_code <= 4'd9);
    key_ok    = key_valid && (state_reg != ST_BLOCKED) &&
                (is_digit || key_code == KEY_HASH || key_code == KEY_STAR);
    full_star = key_ok && (key_code == KEY_STAR) && (len_reg == 3'd4);

    state_next = state_reg;
    fail_next  = fail_reg;
    buf_next   = buf_reg;
    len_next   = len_reg;
`ifdef FECHADURA_PIN_UPDATE_EN
    master_next = master_reg;
`else
    master_next = pin_t'(MASTER_PIN_RST);
`endif
    timer_next = (timer_reg == TW'(TMAX)) ? timer_reg : timer_reg + 1'b1;
    bip_next   = key_ok ? BW'(BIP_CYCLES) : ((bip_reg != '0) ? bip_reg - 1'b1 : bip_reg);

    if (key_ok) begin
      if (is_digit) begin
        buf_next = {buf_reg[2:0], key_code};
        if (len_reg != 3'd4) len_next = len_reg + 3'd1;
      end else begin
        buf_next = '0;
        len_next = 3'd0;
      end
    end

    case (state_reg)
      ST_LOCKED: begin
        if (botao_interno) begin
          state_next = ST_UNLOCKED;
        end else if (full_star) begin
          if (buf_reg == master_reg) begin
            state_next = ST_UNLOCKED;
            fail_next  = 2'd0;
          end else begin
            fail_next = fail_reg + 2'd1;
            if (fail_reg == 2'd2) state_next = ST_BLOCKED;
          end
        end
      end
      ST_UNLOCKED: begin
        if (!sensor_de_contato) begin
          state_next = ST_OPEN;
        end else if (timer_reg == TW'(UNLOCK_CYCLES - 1)) begin
          state_next = ST_LOCKED;
        end
`ifdef FECHADURA_PIN_UPDATE_EN
        else if (full_star) begin
          master_next = buf_reg;
          timer_next  = '0;
        end
`endif
      end
      ST_OPEN: begin
        if (sensor_de_contato) state_next = ST_LOCKED;
      end
      ST_BLOCKED: begin
        if (timer_reg == TW'(BLOCK_CYCLES - 1)) begin
          state_next = ST_LOCKED;
          fail_next  = 2'd0;
        end
      end
      default: state_next = ST_LOCKED;
    endcase

    // Any state change restarts the timer and discards partial entry.
    if (state_next != state_reg) begin
      buf_next   = '0;
      len_next   = 3'd0;
      timer_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_LOCKED;
      buf_reg    <= '0;
      len_reg    <= 3'd0;
      fail_reg   <= 2'd0;
      master_reg <= pin_t'(MASTER_PIN_RST);
      timer_reg  <= '0;
      bip_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      buf_reg    <= buf_next;
      len_reg    <= len_next;
      fail_reg   <= fail_next;
      master_reg <= master_next;
      timer_reg  <= timer_next;
      bip_reg    <= bip_next;
    end
  end

  assign tranca = (state_reg == ST_LOCKED) || (state_reg == ST_BLOCKED);
  assign bip    = (bip_reg != '0) || (state_reg == ST_BLOCKED) ||
                  ((state_reg == ST_OPEN) && (timer_reg >= TW'(UNLOCK_CYCLES)));

  // Entry is left-aligned: oldest digit on display 3, unused positions blank.
  logic [6:0] dhex [4];
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    logic [2:0] pos;
    assign pos      = len_reg + 3'(gi);
    assign dhex[gi] = (pos >= 3'd4) ? seg7(buf_reg[pos[1:0]]) : SEG_BLANK;
  end

  assign dispHex0 = dhex[0];
  assign dispHex1 = dhex[1];
  assign dispHex2 = dhex[2];
  assign dispHex3 = dhex[3];
  assign dispHex4 = seg7({2'b00, fail_reg});
  assign dispHex5 = SEG_BLANK;

endmodule

// File: tb/tb_fechadura_top.sv
// Directed bench for fechadura_top: a keypad model driving columns from the scanned row,
// one task per scenario with inline checks against hand-computed values.
module tb_fechadura_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor = 1'b1;
  logic       botao = 1'b0;
  logic [3:0] col, lin;
  logic [6:0] h0, h1, h2, h3, h4, h5;
  logic       tranca, bip;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int bip_hi = 0;

  logic       pressed = 1'b0;
  logic [1:0] prow = 2'd0, pcol = 2'd0;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  logic [6:0] seg_exp [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (bip === 1'b1) bip_hi++;

  assign col = (pressed && lin[prow] == 1'b0) ? ~(4'b0001 << pcol) : 4'hF;

  fechadura_top dut (
    .clk(clk), .rst(rst), .sensor_de_contato(sensor), .botao_interno(botao),
    .matricial_col(col), .matricial_lin(lin),
    .dispHex0(h0), .dispHex1(h1), .dispHex2(h2), .dispHex3(h3), .dispHex4(h4), .dispHex5(h5),
    .tranca(tranca), .bip(bip)
  );

  task automatic key_pos(input int k, output logic [1:0] r, output logic [1:0] c);
    if (k >= 1 && k <= 9) begin r = 2'((k - 1) / 3); c = 2'((k - 1) % 3); end
    else if (k == 0)  begin r = 2'd3; c = 2'd1; end
    else if (k == 15) begin r = 2'd3; c = 2'd0; end
    else if (k == 13) begin r = 2'd3; c = 2'd2; end
    else              begin r = 2'd0; c = 2'd3; end
  endtask

  task automatic press_start(input int k);
    int w;
    key_pos(k, prow, pcol);
    pressed = 1'b1;
    w = 0;
    while (lin[prow] !== 1'b0 && w < 40) begin @(negedge clk); w++; end
    n_cmp++;
    if (w >= 40) begin n_err++; $display("FAIL row_scan key %0d: row never driven, lin=%b", k, lin); end
  endtask

  task automatic press_end();
    repeat (30) @(negedge clk);
    pressed = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic press(input int k);
    press_start(k);
    press_end();
  endtask

  task automatic enter_pin(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d); press(15);
  endtask

  task automatic wait_tranca(input logic v, input int max, output int t);
    int w;
    w = 0;
    while (tranca !== v && w < max) begin @(negedge clk); w++; end
    t = (tranca === v) ? cyc : -1;
  endtask

  task automatic wait_hex4(input logic [6:0] v, input int max, output int t);
    int w;
    w = 0;
    while (h4 !== v && w < max) begin @(negedge clk); w++; end
    t = (h4 === v) ? cyc : -1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tranca !== 1'b1) begin n_err++; $display("FAIL rst_tranca: got %b want 1", tranca); end
    n_cmp++; if (bip !== 1'b0) begin n_err++; $display("FAIL rst_bip: got %b want 0", bip); end
    n_cmp++; if (lin !== 4'b1110) begin n_err++; $display("FAIL rst_lin: got %b want 1110", lin); end
    n_cmp++; if ({h3, h2, h1, h0, h5} !== {5{S_BLANK}}) begin n_err++; $display("FAIL rst_blank: got %b %b %b %b %b", h3, h2, h1, h0, h5); end
    n_cmp++; if (h4 !== 7'b1000000) begin n_err++; $display("FAIL rst_hex4: got %b want 1000000", h4); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (tranca !== 1'b1 || lin !== 4'b1110) begin n_err++; $display("FAIL post_rst: tranca %b lin %b want 1 1110", tranca, lin); end
    $display("reset: tranca=%b lin=%b hex4=%b", tranca, lin, h4);
  endtask

  task automatic test_entry();
    int b0;
    b0 = bip_hi; press(1);
    n_cmp++; if (bip_hi - b0 != 8) begin n_err++; $display("FAIL bip_len key1: got %0d want 8", bip_hi - b0); end
    n_cmp++; if (h3 !== seg_exp[1] || h2 !== S_BLANK) begin n_err++; $display("FAIL one_digit: h3 %b h2 %b want %b %b", h3, h2, seg_exp[1], S_BLANK); end
    b0 = bip_hi; press(10);
    n_cmp++; if (bip_hi - b0 != 0 || h2 !== S_BLANK) begin n_err++; $display("FAIL key_A_ignored: bip %0d h2 %b want 0 %b", bip_hi - b0, h2, S_BLANK); end
    press(2); press(3);
    b0 = bip_hi; press(4);
    n_cmp++; if (bip_hi - b0 != 8) begin n_err++; $display("FAIL bip_len key4: got %0d want 8", bip_hi - b0); end
    n_cmp++; if ({h3, h2, h1, h0} !== {seg_exp[1], seg_exp[2], seg_exp[3], seg_exp[4]}) begin n_err++; $display("FAIL show_1234: got %b %b %b %b", h3, h2, h1, h0); end
    $display("entry 1234: hex3..0=%b %b %b %b", h3, h2, h1, h0);
    press(5);
    n_cmp++; if ({h3, h2, h1, h0} !== {seg_exp[2], seg_exp[3], seg_exp[4], seg_exp[5]}) begin n_err++; $display("FAIL shift_2345: got %b %b %b %b", h3, h2, h1, h0); end
    b0 = bip_hi; press(13);
    n_cmp++; if ({h3, h2, h1, h0} !== {4{S_BLANK}} || bip_hi - b0 != 8) begin n_err++; $display("FAIL hash_clear: got %b %b %b %b bip %0d", h3, h2, h1, h0, bip_hi - b0); end
    $display("entry shift+hash: hex3=%b", h3);
  endtask

  task automatic test_partial_star();
    press(1); press(2); press(15);
    n_cmp++; if (h3 !== S_BLANK || h4 !== seg_exp[0] || tranca !== 1'b1) begin n_err++; $display("FAIL partial_star: h3 %b h4 %b tranca %b", h3, h4, tranca); end
    $display("partial star: h4=%b tranca=%b", h4, tranca);
  endtask

  task automatic test_unlock();
    int t0, t1;
    press(1); press(2); press(3); press(4);
    press_start(15);
    wait_tranca(1'b0, 60, t0);
    press_end();
    n_cmp++; if (t0 < 0 || h3 !== S_BLANK) begin n_err++; $display("FAIL unlock: t %0d h3 %b want unlocked, blank", t0, h3); end
    wait_tranca(1'b1, 6000, t1);
    n_cmp++; if (t0 < 0 || t1 < 0 || t1 - t0 != 5000) begin n_err++; $display("FAIL relock_time: got %0d want 5000", t1 - t0); end
    $display("unlock/relock: unlocked %0d cycles", t1 - t0);
  endtask

  task automatic test_block();
    int t0, t1;
    enter_pin(1, 1, 1, 1);
    n_cmp++; if (h4 !== seg_exp[1]) begin n_err++; $display("FAIL fail1: got %b want %b", h4, seg_exp[1]); end
    enter_pin(1, 1, 1, 1);
    n_cmp++; if (h4 !== seg_exp[2]) begin n_err++; $display("FAIL fail2: got %b want %b", h4, seg_exp[2]); end
    press(1); press(1); press(1); press(1);
    press_start(15);
    wait_hex4(seg_exp[3], 60, t0);
    press_end();
    n_cmp++; if (t0 < 0 || bip !== 1'b1 || tranca !== 1'b1) begin n_err++; $display("FAIL blocked: t %0d bip %b tranca %b", t0, bip, tranca); end
    press(5);
    n_cmp++; if (h3 !== S_BLANK || bip !== 1'b1) begin n_err++; $display("FAIL blocked_ignore: h3 %b bip %b", h3, bip); end
    wait_hex4(seg_exp[0], 3000, t1);
    n_cmp++; if (t0 < 0 || t1 < 0 || t1 - t0 != 2000) begin n_err++; $display("FAIL block_time: got %0d want 2000", t1 - t0); end
    n_cmp++; if (bip !== 1'b0 || tranca !== 1'b1) begin n_err++; $display("FAIL after_block: bip %b tranca %b want 0 1", bip, tranca); end
    $display("block: duration %0d cycles, hex4=%b", t1 - t0, h4);
  endtask

  task automatic test_open();
    enter_pin(1, 2, 3, 4);
    sensor = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++; if (tranca !== 1'b0 || bip !== 1'b0) begin n_err++; $display("FAIL open_early: tranca %b bip %b want 0 0", tranca, bip); end
    repeat (5010) @(negedge clk);
    n_cmp++; if (tranca !== 1'b0 || bip !== 1'b1) begin n_err++; $display("FAIL open_long: tranca %b bip %b want 0 1", tranca, bip); end
    sensor = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (tranca !== 1'b1 || bip !== 1'b0) begin n_err++; $display("FAIL door_close: tranca %b bip %b want 1 0", tranca, bip); end
    $display("open/close: tranca=%b bip=%b", tranca, bip);
  endtask

  task automatic test_button();
    int t;
    botao = 1'b1; @(negedge clk); botao = 1'b0; @(negedge clk);
    n_cmp++; if (tranca !== 1'b0) begin n_err++; $display("FAIL button: got %b want 0", tranca); end
    wait_tranca(1'b1, 6000, t);
    n_cmp++; if (t < 0) begin n_err++; $display("FAIL button_relock: tranca %b want 1", tranca); end
    $display("button: relocked=%b", tranca);
  endtask

  task automatic test_reset_mid();
    botao = 1'b1; @(negedge clk); botao = 1'b0;
    press(1); press(2);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (tranca !== 1'b1 || h3 !== S_BLANK || lin !== 4'b1110 || h4 !== seg_exp[0]) begin n_err++; $display("FAIL reset_mid: tranca %b h3 %b lin %b h4 %b", tranca, h3, lin, h4); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("reset mid-op: tranca=%b", tranca);
  endtask

  task automatic test_pin_update();
    int t;
    enter_pin(1, 2, 3, 4);
    enter_pin(6, 7, 8, 9);
    n_cmp++; if (tranca !== 1'b0 || h3 !== S_BLANK) begin n_err++; $display("FAIL pin_entry_unlocked: tranca %b h3 %b", tranca, h3); end
    wait_tranca(1'b1, 6000, t);
`ifdef FECHADURA_PIN_UPDATE_EN
    enter_pin(1, 2, 3, 4);
    n_cmp++; if (h4 !== seg_exp[1] || tranca !== 1'b1) begin n_err++; $display("FAIL old_pin_rejected: h4 %b tranca %b", h4, tranca); end
    enter_pin(6, 7, 8, 9);
`else
    enter_pin(6, 7, 8, 9);
    n_cmp++; if (h4 !== seg_exp[1] || tranca !== 1'b1) begin n_err++; $display("FAIL new_pin_rejected: h4 %b tranca %b", h4, tranca); end
    enter_pin(1, 2, 3, 4);
`endif
    n_cmp++; if (t < 0 || tranca !== 1'b0 || h4 !== seg_exp[0]) begin n_err++; $display("FAIL pin_unlock: t %0d tranca %b h4 %b", t, tranca, h4); end
    $display("pin update: tranca=%b hex4=%b", tranca, h4);
  endtask

  initial begin
    test_reset();
    test_entry();
    test_partial_star();
    test_unlock();
    test_block();
    test_open();
    test_button();
    test_reset_mid();
    test_pin_update();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fechadura_top.md
# fechadura_top

Top-level controller of the FPGA door lock. Scans a 4x4 matrix keypad, accumulates a 4-digit PIN, and compares it against a stored master PIN. Drives the lock bolt, the buzzer and six active-low seven-segment displays. It is the root of the lock design and connects directly to board pins.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 20: consecutive stable cycles required to accept a key press and, separately, a release.
- `SCAN_CYCLES`, 4: cycles each keypad row is driven before the scan advances.
- `UNLOCK_CYCLES`, 5000: maximum UNLOCKED time while the door stays closed.
- `BIP_CYCLES`, 8: length of the acknowledge beep.
- `BLOCK_CYCLES`, 2000: lockout duration.
- `MASTER_PIN_RST`, 16'h1234: reset master PIN, 4 BCD digits, first-typed digit in [15:12].

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-low reset.
- `sensor_de_contato` in 1: door contact; 1 = door closed.
- `botao_interno` in 1: inside release button, active high.
- `matricial_col` in 4: keypad columns, active low, idle 4'b1111.
- `matricial_lin` out 4: keypad rows; the scanned row is driven 0, all other rows 1.
- `dispHex0`..`dispHex5` out 7 each: seven-segment outputs, active low, bit order gfedcba.
- `tranca` out 1: bolt; 1 = locked.
- `bip` out 1: buzzer.

## Operation
- Keypad map, listed as row/col index → code:
  - row0: col0..3 = 1, 2, 3, A(10)
  - row1: col0..3 = 4, 5, 6, B(11)
  - row2: col0..3 = 7, 8, 9, C(12)
  - row3: col0..3 = *(15), 0, #(13), D(14)
- Scanner states:
  - SCAN: the row steps 0→1→2→3→0 every `SCAN_CYCLES`.
  - Any column low moves to DEBOUNCE with the row frozen.
  - DEBOUNCE: requires the same column pattern for `DEBOUNCE_CYCLES` cycles, then emits a one-cycle `key_valid` with `key_code`. A pattern change returns to SCAN.
  - HOLD: waits until columns read 1111 for `DEBOUNCE_CYCLES`, then returns to SCAN.
  - If several columns are low, the lowest column index wins.
- Entry buffer: up to 4 digits.
  - A 5th digit shifts out the oldest digit.
  - `#` clears the buffer.
  - A–D are ignored.
  - `*` with fewer than 4 digits clears the buffer and has no other effect.
  - Every accepted key pulses `bip` for `BIP_CYCLES`.
- Controller states:
  - LOCKED (`tranca`=1):
    - Full buffer + `*` equal to master → UNLOCKED, fail count cleared.
    - Full buffer + `*` not equal → fail count +1; on the 3rd failure → BLOCKED.
    - `botao_interno`=1 → UNLOCKED.
  - UNLOCKED (`tranca`=0):
    - `sensor_de_contato` falling (door opened) → OPEN.
    - `UNLOCK_CYCLES` expiring with the door closed → LOCKED.
  - OPEN (`tranca`=0):
    - `bip` is held high while the door stays open longer than `UNLOCK_CYCLES`.
    - Door closes → LOCKED.
  - BLOCKED: all keys ignored; `bip`=1; after `BLOCK_CYCLES` → LOCKED with fail count 0.
- The buffer clears on every `*` and on every state change.
- Displays:
  - `dispHex3`..`dispHex0` show the buffer, oldest digit on `dispHex3`; empty positions are blank (1111111).
  - `dispHex4` shows the fail count (0–3).
  - `dispHex5` is blank.
- Seven-segment codes (gfedcba, active low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

## Timing
- Reset values:
  - `tranca`=1, `bip`=0, `matricial_lin`=4'b1110.
  - `dispHex0..3` and `dispHex5` blank; `dispHex4`=1000000.
  - Master PIN = `MASTER_PIN_RST`; fail count 0; state LOCKED.
- `key_valid` fires `DEBOUNCE_CYCLES`+1 cycles after the columns first go low on the scanned row.
- Buffer and display update one cycle after `key_valid`.
- State and `tranca` change one cycle after the `*` key_valid.
- Reset mid-operation aborts everything immediately and restores the reset values.
- `botao_interno` and `*` on the same cycle: the button has priority.

## Configuration
- `FECHADURA_PIN_UPDATE_EN` defined: in UNLOCKED, a full buffer + `*` replaces the master PIN with the buffer and restarts the `UNLOCK_CYCLES` timer.
- Undefined: that entry only clears the buffer; the master PIN stays at `MASTER_PIN_RST` permanently.

## Structure
- Package `fechadura_pkg`: controller state enum, scanner state enum, key code constants (`KEY_STAR`=15, `KEY_HASH`=13), BCD PIN type (4×4-bit), 7-segment encode function and blank constant.
- One sub-module, `matrix_keypad_scan`: row scan, debounce, `key_valid`/`key_code` generation.
- Controller and display logic stay in the top.

## Test plan
- Reset, then release reset → `tranca`=1, `matricial_lin`=1110, `dispHex4` shows 0, other displays blank.
- Press 1,2,3,4 (each held 30 cycles on its row) → `dispHex3..0` show 1 2 3 4; `bip` pulses 8 cycles per key.
- Door closed, press 1234 then `*` → `tranca`=0; after 5000 idle cycles → `tranca`=1.
- With macro defined: press 1234`*` then 6789`*` → master PIN becomes 6789; later 1234`*` counts as a failure and 6789`*` unlocks.
- Press 1111`*` three times → `dispHex4` goes 1, 2, then state is BLOCKED with `bip`=1; keys ignored for 2000 cycles, then LOCKED with count 0.
- Unlock, then drop `sensor_de_contato` → OPEN; raise it again → `tranca`=1. Separately, `botao_interno` pulse while LOCKED → `tranca`=0.
